clock_mode_ctrl: RTL and testbench
==================================

// Module: clock_mode_ctrl
// PURPOSE
//   Mode/sequencing controller for the HH:MM:SS clock counter.
//   - Debounces three raw keys; runs a RUN/PAUSE/SET state machine.
//   - Drives the counter's count-enable and per-field increment pulses.
//   - Drives a per-digit blink mask for the six HEX displays and the timing LED.
//   - Sits between the 1 Hz divider and the counter, replacing direct key wiring.
// PARAMETERS
//   DB_CYC     1_000_000   clocks a key level must stay stable before it is accepted (20 ms @ 50 MHz)
//   HOLD_CYC   25_000_000  clocks btn_inc is held before auto-repeat starts (0.5 s)
//   REP_CYC    5_000_000   auto-repeat period while btn_inc is held (0.1 s)
//   BLINK_CYC  12_500_000  clocks per blink half-period (2 Hz blink)
// PORTS
//   CLK         in   1  system clock, 50 MHz
//   clr         in   1  asynchronous, active-high reset
//   tick_1hz    in   1  single-CLK pulse from the 1 Hz divider
//   btn_start   in   1  raw key, active-high: start/pause toggle
//   btn_mode    in   1  raw key, active-high: enter/step set mode
//   btn_inc     in   1  raw key, active-high: increment selected field
//   cnt_en      out  1  counter advances one second this cycle
//   inc_sec     out  1  one-cycle pulse: seconds +1 (no carry into minutes)
//   inc_min     out  1  one-cycle pulse: minutes +1 (no carry into hours)
//   inc_hou     out  1  one-cycle pulse: hours +1
//   blink_mask  out  6  1 = blank digit; [1:0] HEX1:0 sec, [3:2] min, [5:4] hour
//   mode        out  3  current state encoding
//   timing      out  1  1 while in RUN
// BEHAVIOUR
//   Reset (clr=1, async): state IDLE; all outputs 0; debounce, repeat and blink counters 0.
//   Debounce (per key): 2-FF synchronizer, then a DB_CYC stability counter.
//   - Press = single-cycle pulse on an accepted 0->1 change.
//   - Total raw-edge-to-press latency = 2 + DB_CYC clocks.
//   States and transitions (taken on press pulses):
//   - IDLE(0): start -> RUN; mode -> SET_HOU.
//   - RUN(1): start -> PAUSE; mode ignored.
//   - PAUSE(2): start -> RUN; mode -> SET_HOU.
//   - SET_HOU(3) -> mode -> SET_MIN(4) -> mode -> SET_SEC(5) -> mode -> PAUSE; start ignored.
//   - Encodings 6 and 7 are unreachable; if ever entered, go to IDLE next cycle.
//   - Start and mode pressed in the same cycle: mode wins; start is dropped.
//   cnt_en: registered (tick_1hz & state==RUN); 1-cycle latency.
//   - A tick coinciding with the RUN->PAUSE transition is still counted (uses the old state).
//   inc_*: only in the matching SET_x state.
//   - Pulse 1 clock after the btn_inc press pulse.
//   - While the debounced level stays high: next pulse after HOLD_CYC, then every REP_CYC.
//   - Repeat counter clears on release or on any state change.
//   - At most one inc_* is high in any cycle; never in RUN/IDLE/PAUSE.
//   blink_mask: free-running phase toggles every BLINK_CYC clocks.
//   - In SET_x with phase=1, the field's two bits are 1; otherwise 6'b000000.
//   - Phase resets to 0 on every state change, so the field is visible at once.
//   timing = (state==RUN), registered. mode is the registered state.
//   Field wrap (59->0, 23->0) is owned by the counter, not this block.
// STRUCTURE
//   Shared header clock_ctrl_defs.vh: state encodings ST_IDLE..ST_SET_SEC; blink-mask field constants.
//   Sub-module btn_debounce #(DB_CYC) (CLK, clr, raw, level, press), instantiated 3x.
//   FSM, repeat timer and blink timer stay inline.
// TESTING (bench params: DB_CYC=4, HOLD_CYC=20, REP_CYC=5, BLINK_CYC=8)
//   1. clr pulse mid-RUN -> mode=0, timing=0, cnt_en=0 and blink_mask=0 in the same cycle.
//   2. Press start (held 10 clk), then 3 tick_1hz pulses -> mode=1, timing=1,
//      exactly 3 cnt_en pulses, each 1 clk after its tick.
//   3. Key bounce 1-0-1-0 at 1-clk intervals, then stable 1 for 10 clk -> exactly one press.
//   4. From PAUSE press mode x3 -> mode 3,4,5.
//      In SET_MIN hold btn_inc 40 clk -> inc_min pulses at +1, +21, +26, +31, +36
//      after the press pulse; no inc_sec/inc_hou.
//   5. In SET_SEC, 32 clk idle -> blink_mask toggles 6'b000000/6'b000011 every 8 clk.
//      Mode press -> PAUSE, mask=0.
//   6. In PAUSE, start and mode pressed in the same clk -> mode=3, not RUN.
//      In RUN, mode press -> stays 1.

Source files
------------

// File: rtl/clock_mode_ctrl_pkg.sv
// clock_mode_ctrl_pkg: state encodings, blink-mask field constants and field lookup.
package clock_mode_ctrl_pkg;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PAUSE   = 3'd2,
      ST_SET_HOU = 3'd3,
      ST_SET_MIN = 3'd4,
      ST_SET_SEC = 3'd5
   } state_e;
   localparam logic [5:0] MASK_SEC = 6'b000011;
   localparam logic [5:0] MASK_MIN = 6'b001100;
   localparam logic [5:0] MASK_HOU = 6'b110000;
   function automatic logic [5:0] field_mask(state_e s);
      return s == ST_SET_HOU ? MASK_HOU : s == ST_SET_MIN ? MASK_MIN : s == ST_SET_SEC ? MASK_SEC : 6'b000000;
   endfunction
endpackage

// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: key/tick inputs and counter/display controls of the clock mode controller.
interface clock_mode_ctrl_if;
   logic tick_1hz, btn_start, btn_mode, btn_inc;
   logic cnt_en, inc_sec, inc_min, inc_hou, timing;
   logic [5:0] blink_mask;
   logic [2:0] mode;
   modport master (
      output tick_1hz, btn_start, btn_mode, btn_inc,
      input  cnt_en, inc_sec, inc_min, inc_hou, blink_mask, mode, timing
   );
   modport slave (
      input  tick_1hz, btn_start, btn_mode, btn_inc,
      output cnt_en, inc_sec, inc_min, inc_hou, blink_mask, mode, timing
   );
endinterface

// File: rtl/clock_mode_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus stability counter; press pulses on an accepted rising level.
module btn_debounce #(
   parameter int DB_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o,
   output logic press_o
);
   localparam int CW = $clog2(DB_CYC + 1);
   logic s1_q, s2_q, lvl_q, prs_q, acc;
   logic [CW-1:0] cnt_q;
   assign acc = (s2_q != lvl_q) && (cnt_q == CW'(DB_CYC - 1));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         lvl_q <= 1'b0;
         prs_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= raw_i;
         s2_q  <= s1_q;
         cnt_q <= (s2_q == lvl_q || acc) ? '0 : cnt_q + 1'b1;
         lvl_q <= acc ? s2_q : lvl_q;
         prs_q <= acc & s2_q;
      end
   assign level_o = lvl_q;
   assign press_o = prs_q;
endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: debounced-key RUN/PAUSE/SET sequencer between the 1 Hz divider and the HH:MM:SS counter;
// drives count-enable, per-field increment pulses with auto-repeat, and the digit blink mask.
module clock_mode_ctrl
   import clock_mode_ctrl_pkg::*;
#(
   parameter int DB_CYC    = 1_000_000,
   parameter int HOLD_CYC  = 25_000_000,
   parameter int REP_CYC   = 5_000_000,
   parameter int BLINK_CYC = 12_500_000
) (
   input logic clk,
   input logic rst,
   clock_mode_ctrl_if.slave bus
);
   localparam int RW = $clog2(HOLD_CYC + 1);
   localparam int BW = $clog2(BLINK_CYC + 1);
   state_e state_q, state_d;
   logic [RW-1:0] rep_q, rep_d;
   logic [BW-1:0] bc_q, bc_d;
   logic [2:0] inc_q;
   logic ph_q, ph_d, cnt_en_q, timing_q;
   logic start_p, mode_p, inc_p, inc_lvl, chg, fire, wrap;
   btn_debounce #(.DB_CYC(DB_CYC)) u_db_start (.clk(clk), .rst(rst), .raw_i(bus.btn_start), .level_o(), .press_o(start_p));
   btn_debounce #(.DB_CYC(DB_CYC)) u_db_mode  (.clk(clk), .rst(rst), .raw_i(bus.btn_mode),  .level_o(), .press_o(mode_p));
   btn_debounce #(.DB_CYC(DB_CYC)) u_db_inc   (.clk(clk), .rst(rst), .raw_i(bus.btn_inc),   .level_o(inc_lvl), .press_o(inc_p));
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_PAUSE: state_d = mode_p ? ST_SET_HOU : start_p ? ST_RUN : state_q;
         ST_RUN:            state_d = start_p ? ST_PAUSE : ST_RUN;
         ST_SET_HOU:        state_d = mode_p ? ST_SET_MIN : ST_SET_HOU;
         ST_SET_MIN:        state_d = mode_p ? ST_SET_SEC : ST_SET_MIN;
         ST_SET_SEC:        state_d = mode_p ? ST_PAUSE : ST_SET_SEC;
         default:           state_d = ST_IDLE;
      endcase
   end
   // rep_q counts clocks since the press; reaching HOLD_CYC fires and reloads one REP_CYC short of it
   assign chg   = state_d != state_q;
   assign fire  = inc_p | (inc_lvl && rep_q == RW'(HOLD_CYC));
   assign rep_d = (chg || !inc_lvl) ? '0 : inc_p ? RW'(1) : (rep_q == RW'(HOLD_CYC)) ? RW'(HOLD_CYC - REP_CYC + 1) : (rep_q != '0) ? rep_q + 1'b1 : '0;
   assign wrap  = bc_q == BW'(BLINK_CYC - 1);
   assign bc_d  = (chg || wrap) ? '0 : bc_q + 1'b1;
   assign ph_d  = !chg && (ph_q ^ wrap);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= ST_IDLE;
         rep_q    <= '0;
         bc_q     <= '0;
         ph_q     <= 1'b0;
         cnt_en_q <= 1'b0;
         timing_q <= 1'b0;
         inc_q    <= 3'b000;
      end else begin
         state_q  <= state_d;
         rep_q    <= rep_d;
         bc_q     <= bc_d;
         ph_q     <= ph_d;
         cnt_en_q <= bus.tick_1hz && state_q == ST_RUN;
         timing_q <= state_d == ST_RUN;
         inc_q    <= fire ? {state_q == ST_SET_HOU, state_q == ST_SET_MIN, state_q == ST_SET_SEC} : 3'b000;
      end
   assign bus.cnt_en     = cnt_en_q;
   assign bus.timing     = timing_q;
   assign bus.mode       = state_q;
   assign bus.inc_hou    = inc_q[2];
   assign bus.inc_min    = inc_q[1];
   assign bus.inc_sec    = inc_q[0];
   assign bus.blink_mask = ph_q ? field_mask(state_q) : 6'b000000;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed scenario tasks for clock_mode_ctrl with small timing parameters.
module tb_clock_mode_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int checks = 0;
   int passed = 0;
   clock_mode_ctrl_if bus ();
   clock_mode_ctrl #(.DB_CYC(4), .HOLD_CYC(20), .REP_CYC(5), .BLINK_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press_key(input int k, input int hold, input int gap);
      if (k == 0) bus.btn_start = 1'b1;
      else if (k == 1) bus.btn_mode = 1'b1;
      else bus.btn_inc = 1'b1;
      step(hold);
      bus.btn_start = 1'b0;
      bus.btn_mode  = 1'b0;
      bus.btn_inc   = 1'b0;
      step(gap);
   endtask

   task automatic test_reset;
      step(3);
      checks++; if (bus.mode !== 3'd0) $display("FAIL reset_mode: got %0d want 0", bus.mode); else passed++;
      checks++; if (bus.timing !== 1'b0) $display("FAIL reset_timing: got %b want 0", bus.timing); else passed++;
      checks++; if (bus.cnt_en !== 1'b0) $display("FAIL reset_cnt_en: got %b want 0", bus.cnt_en); else passed++;
      checks++; if (bus.blink_mask !== 6'b0) $display("FAIL reset_blink: got %b want 000000", bus.blink_mask); else passed++;
      checks++; if ({bus.inc_hou, bus.inc_min, bus.inc_sec} !== 3'b000) $display("FAIL reset_inc: got %b want 000", {bus.inc_hou, bus.inc_min, bus.inc_sec}); else passed++;
      rst = 1'b0;
      step(2);
      bus.tick_1hz = 1'b1;
      step(1);
      bus.tick_1hz = 1'b0;
      checks++; if (bus.cnt_en !== 1'b0) $display("FAIL idle_tick: got cnt_en %b want 0", bus.cnt_en); else passed++;
      step(1);
   endtask

   task automatic test_run;
      int extra = 0;
      bus.btn_start = 1'b1;
      step(6);
      checks++; if (bus.mode !== 3'd0) $display("FAIL start_early: got mode %0d want 0", bus.mode); else passed++;
      step(1);
      checks++; if (bus.mode !== 3'd1) $display("FAIL start_run: got mode %0d want 1", bus.mode); else passed++;
      checks++; if (bus.timing !== 1'b1) $display("FAIL run_timing: got %b want 1", bus.timing); else passed++;
      step(3);
      bus.btn_start = 1'b0;
      step(8);
      for (int t = 0; t < 3; t++) begin
         bus.tick_1hz = 1'b1;
         step(1);
         bus.tick_1hz = 1'b0;
         checks++; if (bus.cnt_en !== 1'b1) $display("FAIL cnt_en_tick%0d: got %b want 1", t, bus.cnt_en); else passed++;
         for (int i = 0; i < 4; i++) begin
            step(1);
            if (bus.cnt_en !== 1'b0) extra++;
         end
      end
      checks++; if (extra !== 0) $display("FAIL cnt_en_extra: got %0d extra pulses want 0", extra); else passed++;
   endtask

   task automatic test_clr_mid_run;
      bus.tick_1hz = 1'b1;
      step(1);
      checks++; if (bus.cnt_en !== 1'b1) $display("FAIL clr_pre_cnt_en: got %b want 1", bus.cnt_en); else passed++;
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.mode !== 3'd0) $display("FAIL clr_mode: got %0d want 0", bus.mode); else passed++;
      checks++; if (bus.timing !== 1'b0) $display("FAIL clr_timing: got %b want 0", bus.timing); else passed++;
      checks++; if (bus.cnt_en !== 1'b0) $display("FAIL clr_cnt_en: got %b want 0", bus.cnt_en); else passed++;
      checks++; if (bus.blink_mask !== 6'b0) $display("FAIL clr_blink: got %b want 000000", bus.blink_mask); else passed++;
      bus.tick_1hz = 1'b0;
      step(1);
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_bounce;
      int chg = 0;
      logic [2:0] prev;
      prev = bus.mode;
      for (int i = 0; i < 24; i++) begin
         bus.btn_start = (i == 0 || i == 2 || (i >= 4 && i < 14));
         step(1);
         if (bus.mode !== prev) chg++;
         prev = bus.mode;
      end
      bus.btn_start = 1'b0;
      step(8);
      checks++; if (chg !== 1) $display("FAIL bounce_presses: got %0d mode changes want 1", chg); else passed++;
      checks++; if (bus.mode !== 3'd1) $display("FAIL bounce_mode: got %0d want 1", bus.mode); else passed++;
   endtask

   task automatic test_set_inc;
      int offs[$];
      int exp_off[5] = '{7, 27, 32, 37, 42};
      int bad = 0;
      int n0;
      press_key(0, 8, 8);
      checks++; if (bus.mode !== 3'd2) $display("FAIL pause_mode: got %0d want 2", bus.mode); else passed++;
      checks++; if (bus.timing !== 1'b0) $display("FAIL pause_timing: got %b want 0", bus.timing); else passed++;
      bus.btn_inc = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) bus.btn_inc = 1'b0;
         step(1);
         if (bus.inc_hou || bus.inc_min || bus.inc_sec) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL pause_inc: got %0d inc pulses want 0", bad); else passed++;
      press_key(1, 8, 8);
      checks++; if (bus.mode !== 3'd3) $display("FAIL set_hou: got %0d want 3", bus.mode); else passed++;
      press_key(1, 8, 8);
      checks++; if (bus.mode !== 3'd4) $display("FAIL set_min: got %0d want 4", bus.mode); else passed++;
      bad = 0;
      n0 = cyc;
      bus.btn_inc = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         step(1);
         if (bus.inc_min) offs.push_back(cyc - n0);
         if (bus.inc_sec || bus.inc_hou) bad++;
         if (i == 40) bus.btn_inc = 1'b0;
      end
      checks++; if (offs.size() !== 5) $display("FAIL inc_min_count: got %0d pulses want 5", offs.size()); else passed++;
      for (int k = 0; k < 5; k++)
         if (k < offs.size()) begin
            checks++; if (offs[k] !== exp_off[k]) $display("FAIL inc_min_at%0d: got +%0d want +%0d", k, offs[k], exp_off[k]); else passed++;
         end
      checks++; if (bad !== 0) $display("FAIL inc_other_fields: got %0d pulses want 0", bad); else passed++;
   endtask

   task automatic test_blink;
      logic [5:0] want;
      bus.btn_mode = 1'b1;
      step(7);
      checks++; if (bus.mode !== 3'd5) $display("FAIL set_sec: got %0d want 5", bus.mode); else passed++;
      for (int i = 0; i < 32; i++) begin
         want = ((i / 8) % 2 == 1) ? 6'b000011 : 6'b000000;
         checks++; if (bus.blink_mask !== want) $display("FAIL blink_c%0d: got %b want %b", i, bus.blink_mask, want); else passed++;
         if (i == 0) bus.btn_mode = 1'b0;
         step(1);
      end
      bus.btn_mode = 1'b1;
      step(7);
      checks++; if (bus.mode !== 3'd2) $display("FAIL sec_to_pause: got %0d want 2", bus.mode); else passed++;
      checks++; if (bus.blink_mask !== 6'b0) $display("FAIL pause_blink: got %b want 000000", bus.blink_mask); else passed++;
      bus.btn_mode = 1'b0;
      step(8);
   endtask

   task automatic test_back_to_back;
      int bad = 0;
      bus.btn_start = 1'b1;
      bus.btn_mode  = 1'b1;
      step(7);
      checks++; if (bus.mode !== 3'd3) $display("FAIL both_keys: got %0d want 3", bus.mode); else passed++;
      step(3);
      checks++; if (bus.mode !== 3'd3) $display("FAIL both_keys_hold: got %0d want 3", bus.mode); else passed++;
      bus.btn_start = 1'b0;
      bus.btn_mode  = 1'b0;
      step(8);
      press_key(0, 8, 8);
      checks++; if (bus.mode !== 3'd3) $display("FAIL set_start_ignored: got %0d want 3", bus.mode); else passed++;
      press_key(1, 8, 8);
      press_key(1, 8, 8);
      press_key(1, 8, 8);
      checks++; if (bus.mode !== 3'd2) $display("FAIL set_cycle_pause: got %0d want 2", bus.mode); else passed++;
      press_key(0, 8, 8);
      checks++; if (bus.mode !== 3'd1) $display("FAIL pause_to_run: got %0d want 1", bus.mode); else passed++;
      press_key(1, 8, 8);
      checks++; if (bus.mode !== 3'd1) $display("FAIL run_mode_ignored: got %0d want 1", bus.mode); else passed++;
      checks++; if (bus.timing !== 1'b1) $display("FAIL run_mode_timing: got %b want 1", bus.timing); else passed++;
      bus.btn_inc = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) bus.btn_inc = 1'b0;
         step(1);
         if (bus.inc_hou || bus.inc_min || bus.inc_sec) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL run_inc: got %0d inc pulses want 0", bad); else passed++;
   endtask

   initial begin
      bus.tick_1hz  = 1'b0;
      bus.btn_start = 1'b0;
      bus.btn_mode  = 1'b0;
      bus.btn_inc   = 1'b0;
      test_reset();
      test_run();
      test_clr_mid_run();
      test_bounce();
      test_set_inc();
      test_blink();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
